// File: rtl/spi_rx_fifo.sv
// spi_rx_fifo: SPI master receive drain with acknowledge FSM and a stream FIFO.
// Define SPI_RX_OVR_CNT_EN to build the saturating dropped-byte counter on ovr_cnt.
module spi_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] rx_data,
    input  logic             rx_not_empty,
    output logic             read,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [AW:0]      count,
    output logic             full,
    output logic             overflow,
    input  logic             clr_ovr,
    output logic [7:0]       ovr_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_t;

    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             capture;
    logic             push;
    logic             drop;
    logic             pop;

    assign full    = (count == FULL_CNT);
    assign m_valid = (count != '0);
    assign m_data  = mem[rd_ptr];
    assign read    = (state == ACK);
    assign push    = capture & ~full;
    assign drop    = capture & full;
    assign pop     = m_valid & m_ready;

    // Acknowledge FSM register; read is decoded from the registered state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Take one byte in IDLE, spend exactly one cycle acknowledging it.
    always_comb begin
        state_nx = state;
        capture  = 1'b0;
        unique case (state)
            IDLE: begin
                if (rx_not_empty) begin
                    capture  = 1'b1;
                    state_nx = ACK;
                end
            end
            ACK:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Storage array; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= rx_data;
        end
    end

    // Pointers wrap naturally at DEPTH; occupancy kept in its own register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sticky overflow flag; a drop in the same cycle as a clear wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_ovr) begin
            overflow <= 1'b0;
        end
    end

`ifdef SPI_RX_OVR_CNT_EN
    // Saturating count of dropped bytes; a drop during a clear restarts at one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovr_cnt <= 8'h00;
        end else if (clr_ovr) begin
            ovr_cnt <= drop ? 8'h01 : 8'h00;
        end else if (drop && ovr_cnt != 8'hFF) begin
            ovr_cnt <= ovr_cnt + 8'h01;
        end
    end
`else
    assign ovr_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_spi_rx_fifo.sv
// tb_spi_rx_fifo: vector table, directed corner sequences and random traffic
// against a queue-based model of the receive drain.
module tb_spi_rx_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;
    localparam int AW = $clog2(DEPTH);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [WIDTH-1:0] rx_data = '0;
    logic             rx_not_empty = 1'b0;
    logic             read;
    logic [WIDTH-1:0] m_data;
    logic             m_valid;
    logic             m_ready = 1'b0;
    logic [AW:0]      count;
    logic             full;
    logic             overflow;
    logic             clr_ovr = 1'b0;
    logic [7:0]       ovr_cnt;

    spi_rx_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .rx_data(rx_data),
        .rx_not_empty(rx_not_empty),
        .read(read),
        .m_data(m_data),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .count(count),
        .full(full),
        .overflow(overflow),
        .clr_ovr(clr_ovr),
        .ovr_cnt(ovr_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // Reference: stored bytes in order, whether an acknowledge is owed,
    // sticky overflow and the dropped-byte tally.
    logic [7:0] q[$];
    bit         ack_owed;
    bit         ovf_m;
    int         drops_m;
    int         read_pulses;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic model_reset();
        q.delete();
        ack_owed = 0;
        ovf_m = 0;
        drops_m = 0;
    endtask

    function automatic logic [7:0] exp_ocnt();
`ifdef SPI_RX_OVR_CNT_EN
        return 8'(drops_m);
`else
        return 8'h00;
`endif
    endfunction

    task automatic check_model();
        check("read", read, ack_owed);
        check("count", count, q.size());
        check("m_valid", m_valid, q.size() != 0);
        check("full", full, q.size() == DEPTH);
        check("overflow", overflow, ovf_m);
        check("ovr_cnt", ovr_cnt, exp_ocnt());
        if (q.size() != 0) check("m_data", m_data, q[0]);
    endtask

    // One clock: master offers a byte while its flag is set and no
    // acknowledge is outstanding; full is judged before this edge's pop.
    task automatic tick();
        bit         was_read;
        bit         was_full;
        bit         take;
        bit         pop;
        bit         lost;
        logic [7:0] d;
        was_read = read;
        was_full = (q.size() == DEPTH);
        pop      = (q.size() != 0) && m_ready;
        take     = rx_not_empty && !ack_owed;
        d        = rx_data;
        lost     = take && was_full;
        @(posedge clk);
        #1;
        if (pop) void'(q.pop_front());
        if (take && !was_full) q.push_back(d);
        if (lost) ovf_m = 1;
        else if (clr_ovr) ovf_m = 0;
        if (clr_ovr) drops_m = lost ? 1 : 0;
        else if (lost && drops_m < 255) drops_m++;
        ack_owed = take;
        if (was_read) rx_not_empty = 1'b0;
        if (read) read_pulses++;
        check_model();
    endtask

    task automatic push_byte(logic [7:0] b);
        int guard;
        guard = 0;
        while (rx_not_empty && guard < 20) begin
            tick();
            guard++;
        end
        check("push_wait", rx_not_empty, 1'b0);
        rx_data = b;
        rx_not_empty = 1'b1;
        tick();
        check("push_read", read, 1'b1);
        tick();
    endtask

    task automatic drain_all();
        int guard;
        guard = 0;
        m_ready = 1'b1;
        while (m_valid && guard < 40) begin
            tick();
            guard++;
        end
        m_ready = 1'b0;
        check("drain_empty", m_valid, 1'b0);
    endtask

    typedef struct {
        bit         offer;
        logic [7:0] d;
        bit         mr;
        bit         e_read;
        int         e_count;
        bit         e_valid;
        logic [7:0] e_data;
    } vec_t;

    vec_t tbl[5];

    initial begin
        int c0;
        int p0;

        tbl[0] = '{1, 8'hA5, 0, 1, 1, 1, 8'hA5};
        tbl[1] = '{0, 8'h00, 0, 0, 1, 1, 8'hA5};
        tbl[2] = '{0, 8'h00, 1, 0, 0, 0, 8'h00};
        tbl[3] = '{0, 8'h00, 1, 0, 0, 0, 8'h00};
        tbl[4] = '{0, 8'h00, 0, 0, 0, 0, 8'h00};

        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_read", read, 1'b0);
        check("rst_count", count, 0);
        check("rst_valid", m_valid, 1'b0);
        check("rst_full", full, 1'b0);
        check("rst_ovf", overflow, 1'b0);
        check("rst_ocnt", ovr_cnt, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 5; i++) begin
            if (tbl[i].offer) begin
                rx_data = tbl[i].d;
                rx_not_empty = 1'b1;
            end
            m_ready = tbl[i].mr;
            tick();
            check($sformatf("vec%0d_read", i), read, tbl[i].e_read);
            check($sformatf("vec%0d_count", i), count, tbl[i].e_count);
            check($sformatf("vec%0d_valid", i), m_valid, tbl[i].e_valid);
            if (tbl[i].e_valid)
                check($sformatf("vec%0d_data", i), m_data, tbl[i].e_data);
        end
        m_ready = 1'b0;

        for (int i = 1; i <= 8; i++) push_byte(8'(i));
        check("fill_full", full, 1'b1);
        check("fill_count", count, 8);
        push_byte(8'h09);
        check("drop_ovf", overflow, 1'b1);
        check("drop_count", count, 8);
        m_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            check($sformatf("drain%0d", i), m_data, i);
            tick();
        end
        m_ready = 1'b0;
        check("drained", m_valid, 1'b0);
        push_byte(8'h0A);
        check("wrap_data", m_data, 8'h0A);
        drain_all();

        push_byte(8'h31);
        push_byte(8'h32);
        push_byte(8'h33);
        rx_data = 8'h34;
        rx_not_empty = 1'b1;
        m_ready = 1'b1;
        tick();
        check("pushpop_count", count, 3);
        check("pushpop_head", m_data, 8'h32);
        m_ready = 1'b0;
        tick();
        drain_all();

        p0 = read_pulses;
        c0 = count;
        rx_data = 8'hB1;
        rx_not_empty = 1'b1;
        tick();
        tick();
        rx_data = 8'hB2;
        rx_not_empty = 1'b1;
        tick();
        tick();
        tick();
        check("ackbyte_count", count, c0 + 2);
        check("ackbyte_pulses", read_pulses - p0, 2);
        check("ackbyte_first", m_data, 8'hB1);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        check("ackbyte_second", m_data, 8'hB2);
        drain_all();

        clr_ovr = 1'b1;
        tick();
        clr_ovr = 1'b0;
        check("clr_ovf", overflow, 1'b0);
        for (int i = 0; i < 8; i++) push_byte(8'(8'h40 + i));
        rx_data = 8'h4F;
        rx_not_empty = 1'b1;
        clr_ovr = 1'b1;
        tick();
        clr_ovr = 1'b0;
        check("clr_drop_ovf", overflow, 1'b1);
        tick();
`ifdef SPI_RX_OVR_CNT_EN
        check("clr_drop_ocnt", ovr_cnt, 8'h01);
        for (int i = 0; i < 300; i++) push_byte(8'(i));
        check("ocnt_sat", ovr_cnt, 8'hFF);
        clr_ovr = 1'b1;
        tick();
        clr_ovr = 1'b0;
        check("ocnt_clr", ovr_cnt, 8'h00);
`else
        check("ocnt_tied", ovr_cnt, 8'h00);
`endif
        drain_all();

        for (int i = 0; i < 4; i++) push_byte(8'(8'h60 + i));
        rx_data = 8'h64;
        rx_not_empty = 1'b1;
        tick();
        check("pre_rst_read", read, 1'b1);
        check("pre_rst_count", count, 5);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_read", read, 1'b0);
        check("arst_count", count, 0);
        check("arst_valid", m_valid, 1'b0);
        check("arst_ovf", overflow, 1'b0);
        rx_not_empty = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        push_byte(8'h5A);
        check("post_rst_data", m_data, 8'h5A);
        check("post_rst_count", count, 1);

        for (int i = 0; i < 500; i++) begin
            if (!rx_not_empty && ($urandom % 3 == 0)) begin
                rx_data = 8'($urandom);
                rx_not_empty = 1'b1;
            end
            m_ready = ($urandom % 4 == 0);
            clr_ovr = ($urandom % 16 == 0);
            tick();
        end
        m_ready = 1'b0;
        clr_ovr = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
